// File: rtl/xalu_word_seq_if.sv
// ---------------------------------------------------------------------------
// xalu_word_seq_if
// Host-side command/result bundle for xalu_word_seq.
//   master : host (drives start/op/com/cin/a/b, receives status and result)
//   slave  : sequencer (receives command, drives busy/done/result/flags)
// Signals:
//   start, op[2:0], com, cin, a[W-1:0], b[W-1:0]   host -> sequencer
//   busy, done, result[W-1:0], cout, zero, neg_zero, equ   sequencer -> host
// W = 4*NIBBLES.
// ---------------------------------------------------------------------------
interface xalu_word_seq_if #(
  parameter int NIBBLES = 4
);
  localparam int W = 4 * NIBBLES;

  logic         start;
  logic [2:0]   op;
  logic         com;
  logic         cin;
  logic [W-1:0] a;
  logic [W-1:0] b;

  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         cout;
  logic         zero;
  logic         neg_zero;
  logic         equ;

  modport master (
    output start, op, com, cin, a, b,
    input  busy, done, result, cout, zero, neg_zero, equ
  );

  modport slave (
    input  start, op, com, cin, a, b,
    output busy, done, result, cout, zero, neg_zero, equ
  );
endinterface

// File: rtl/xalu_word_seq.sv
// ---------------------------------------------------------------------------
// xalu_word_seq
// Builds word-wide operations from one external 4-bit ALU slice by driving it
// one nibble per cycle and chaining the carry between passes.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   host (slave)        command in (start/op/com/cin/a/b), status and
//                       result out (busy/done/result/cout/zero/neg_zero/equ)
//   alu_a, alu_b        nibble operands to the slice
//   alu_f, alu_com      function code / complement mode to the slice
//   alu_ci_right/left   carry inputs to the slice
//   alu_d               slice result nibble
//   alu_co_left/right   slice carry outputs
//   alu_equ             slice nibble equality
//
// Op codes: 0 ADD, 1 AND, 2 OR, 3 XOR, 4 PASSA, 5 PASSB, 6 SHR, 7 SHL.
// SHR walks nibbles MSB first with the carry entering on the left; all other
// ops walk LSB first with the carry entering on the right.
// ---------------------------------------------------------------------------
module xalu_word_seq #(
  parameter int NIBBLES = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  xalu_word_seq_if.slave    host,
  output logic [3:0]        alu_a,
  output logic [3:0]        alu_b,
  output logic [2:0]        alu_f,
  output logic              alu_com,
  output logic              alu_ci_right,
  output logic              alu_ci_left,
  input  logic [3:0]        alu_d,
  input  logic              alu_co_left,
  input  logic              alu_co_right,
  input  logic              alu_equ
);
  localparam int W  = 4 * NIBBLES;
  localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SHR = 3'd6;
  localparam logic [2:0] OP_SHL = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state_reg, state_next;

  logic [2:0]     op_reg;
  logic           com_reg;
  logic           cin_reg;
  logic [W-1:0]   a_reg;
  logic [W-1:0]   b_reg;
  logic [CW-1:0]  cnt_reg;
  logic           carry_reg;
  logic           equ_acc_reg;

  logic [W-1:0]   result_reg;
  logic           cout_reg;
  logic           zero_reg;
  logic           neg_zero_reg;
  logic           equ_reg;

  logic [W-1:0]   result_next;
  logic [3:0]     a_nib [NIBBLES];
  logic [3:0]     b_nib [NIBBLES];

  logic           accept;
  logic           is_shr;
  logic           first_nib;
  logic           last_nib;
  logic [CW-1:0]  idx;
  logic           run;

  assign run       = (state_reg == RUN);
  // DONE also accepts so back-to-back commands need no idle cycle.
  assign accept    = host.start && (state_reg != RUN);
  assign is_shr    = (op_reg == OP_SHR);
  assign first_nib = (cnt_reg == '0);
  assign last_nib  = (cnt_reg == CW'(NIBBLES - 1));
  // Physical nibble index: step counter for LSB-first ops, mirrored for SHR.
  assign idx       = is_shr ? (CW'(NIBBLES - 1) - cnt_reg) : cnt_reg;

  // Split operands into nibbles and merge the slice result into its lane.
  generate
    for (genvar gi = 0; gi < NIBBLES; gi++) begin : g_nib
      assign a_nib[gi] = a_reg[4*gi +: 4];
      assign b_nib[gi] = b_reg[4*gi +: 4];
      assign result_next[4*gi +: 4] = (run && (idx == CW'(gi))) ? alu_d
                                                                : result_reg[4*gi +: 4];
    end
  endgenerate

  // Next-state and slice drive; slice inputs are muxes of registered state only.
  always_comb begin
    state_next   = state_reg;
    alu_a        = 4'd0;
    alu_b        = 4'd0;
    alu_f        = 3'd0;
    alu_com      = 1'b0;
    alu_ci_right = 1'b0;
    alu_ci_left  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (host.start) state_next = RUN;
      end
      RUN: begin
        alu_a   = a_nib[idx];
        alu_b   = b_nib[idx];
        alu_f   = op_reg;
        alu_com = com_reg;
        if (is_shr) alu_ci_left  = first_nib ? cin_reg : carry_reg;
        else        alu_ci_right = first_nib ? cin_reg : carry_reg;
        if (last_nib) state_next = DONE;
      end
      DONE: begin
        state_next = host.start ? RUN : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      op_reg       <= 3'd0;
      com_reg      <= 1'b0;
      cin_reg      <= 1'b0;
      a_reg        <= '0;
      b_reg        <= '0;
      cnt_reg      <= '0;
      carry_reg    <= 1'b0;
      equ_acc_reg  <= 1'b0;
      result_reg   <= '0;
      cout_reg     <= 1'b0;
      zero_reg     <= 1'b0;
      neg_zero_reg <= 1'b0;
      equ_reg      <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        op_reg      <= host.op;
        com_reg     <= host.com;
        cin_reg     <= host.cin;
        a_reg       <= host.a;
        b_reg       <= host.b;
        cnt_reg     <= '0;
        equ_acc_reg <= 1'b1;
      end else if (run) begin
        result_reg  <= result_next;
        carry_reg   <= is_shr ? alu_co_right : alu_co_left;
        equ_acc_reg <= equ_acc_reg & alu_equ;
        cnt_reg     <= cnt_reg + CW'(1);
        if (last_nib) begin
          // Flags land on the same edge as done, from the fully assembled word.
          zero_reg     <= (result_next == '0);
          neg_zero_reg <= (result_next == '1);
          equ_reg      <= equ_acc_reg & alu_equ;
          if ((op_reg == OP_ADD) || (op_reg == OP_SHL)) cout_reg <= alu_co_left;
          else if (is_shr)                              cout_reg <= alu_co_right;
          else                                          cout_reg <= 1'b0;
        end
      end
    end
  end

  assign host.busy     = (state_reg != IDLE);
  assign host.done     = (state_reg == DONE);
  assign host.result   = result_reg;
  assign host.cout     = cout_reg;
  assign host.zero     = zero_reg;
  assign host.neg_zero = neg_zero_reg;
  assign host.equ      = equ_reg;
endmodule

// File: tb/tb_xalu_word_seq.sv
// ---------------------------------------------------------------------------
// tb_xalu_word_seq
// Directed bench for xalu_word_seq (NIBBLES=4) with a behavioural 4-bit slice.
// Table of vectors plus hand-written multi-cycle sequences (SHR nibble order,
// back-to-back start, dropped start during RUN, reset mid-operation).
// ---------------------------------------------------------------------------
module tb_xalu_word_seq;
  localparam int NIBBLES = 4;
  localparam int W = 4 * NIBBLES;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic [3:0] alu_a, alu_b, alu_d;
  logic [2:0] alu_f;
  logic       alu_com, alu_ci_right, alu_ci_left;
  logic       alu_co_left, alu_co_right, alu_equ;
  logic [4:0] slice_sum;
  logic [3:0] slice_raw;

  int n_cmp = 0;
  int n_err = 0;

  xalu_word_seq_if #(.NIBBLES(NIBBLES)) host_if ();

  xalu_word_seq #(.NIBBLES(NIBBLES)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .host         (host_if),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_f        (alu_f),
    .alu_com      (alu_com),
    .alu_ci_right (alu_ci_right),
    .alu_ci_left  (alu_ci_left),
    .alu_d        (alu_d),
    .alu_co_left  (alu_co_left),
    .alu_co_right (alu_co_right),
    .alu_equ      (alu_equ)
  );

  always #5 clk = ~clk;

  // External slice: carries come from the true result, com inverts only d.
  always_comb begin
    slice_sum    = 5'(alu_a) + 5'(alu_b) + 5'(alu_ci_right);
    slice_raw    = 4'd0;
    alu_co_left  = 1'b0;
    alu_co_right = 1'b0;
    case (alu_f)
      3'd0: begin slice_raw = slice_sum[3:0]; alu_co_left = slice_sum[4]; end
      3'd1: slice_raw = alu_a & alu_b;
      3'd2: slice_raw = alu_a | alu_b;
      3'd3: slice_raw = alu_a ^ alu_b;
      3'd4: slice_raw = alu_a;
      3'd5: slice_raw = alu_b;
      3'd6: begin slice_raw = {alu_ci_left, alu_a[3:1]}; alu_co_right = alu_a[0]; end
      3'd7: begin slice_raw = {alu_a[2:0], alu_ci_right}; alu_co_left = alu_a[3]; end
      default: slice_raw = 4'd0;
    endcase
    alu_d   = alu_com ? ~slice_raw : slice_raw;
    alu_equ = (alu_a == alu_b);
  end

  typedef struct {
    logic [2:0]   op;
    logic         com;
    logic         cin;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic         cout;
    logic         zero;
    logic         nz;
    logic         equ;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Waits up to a bounded number of edges for done; returns edges counted.
  task automatic wait_done(output int cycles);
    cycles = 0;
    while (cycles < 20) begin
      @(posedge clk); #1;
      cycles++;
      if (host_if.done) break;
    end
  endtask

  task automatic drive_cmd(input logic [2:0] op, input logic com, input logic cin,
                           input logic [W-1:0] a, input logic [W-1:0] b);
    host_if.op  = op;
    host_if.com = com;
    host_if.cin = cin;
    host_if.a   = a;
    host_if.b   = b;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int cyc;
    @(negedge clk);
    drive_cmd(v.op, v.com, v.cin, v.a, v.b);
    host_if.start = 1'b1;
    @(posedge clk); #1;
    host_if.start = 1'b0;
    // Scramble inputs: the latched command must be used.
    drive_cmd(~v.op, ~v.com, ~v.cin, ~v.a, v.a);
    check($sformatf("%s busy_after_accept", tag), 32'(host_if.busy), 32'd1);
    wait_done(cyc);
    check($sformatf("%s done_latency", tag), 32'(cyc), 32'(NIBBLES));
    check($sformatf("%s result", tag), 32'(host_if.result), 32'(v.res));
    check($sformatf("%s cout", tag), 32'(host_if.cout), 32'(v.cout));
    check($sformatf("%s zero", tag), 32'(host_if.zero), 32'(v.zero));
    check($sformatf("%s neg_zero", tag), 32'(host_if.neg_zero), 32'(v.nz));
    check($sformatf("%s equ", tag), 32'(host_if.equ), 32'(v.equ));
    check($sformatf("%s alu_idle_in_done", tag),
          32'({alu_a, alu_b, alu_f, alu_com, alu_ci_right, alu_ci_left}), 32'd0);
    @(posedge clk); #1;
    check($sformatf("%s busy_end", tag), 32'({host_if.busy, host_if.done}), 32'd0);
    $display("vec %s op=%0d a=%h b=%h -> result=%h cout=%b zero=%b nz=%b equ=%b",
             tag, v.op, v.a, v.b, host_if.result, host_if.cout, host_if.zero,
             host_if.neg_zero, host_if.equ);
  endtask

  initial begin
    int cyc;
    logic [3:0] seq [4];

    //           op    com   cin   a         b         res       co zr nz eq
    vecs[0]  = '{3'd0, 1'b0, 1'b0, 16'h1234, 16'h0FFF, 16'h2233, 0, 0, 0, 0};
    vecs[1]  = '{3'd0, 1'b0, 1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1, 1, 0, 0};
    vecs[2]  = '{3'd7, 1'b0, 1'b1, 16'h8001, 16'h0000, 16'h0003, 1, 0, 0, 0};
    vecs[3]  = '{3'd6, 1'b0, 1'b0, 16'h8001, 16'h0000, 16'h4000, 1, 0, 0, 0};
    vecs[4]  = '{3'd3, 1'b1, 1'b0, 16'h5A5A, 16'h5A5A, 16'hFFFF, 0, 0, 1, 1};
    vecs[5]  = '{3'd1, 1'b0, 1'b1, 16'hF0F0, 16'h3C3C, 16'h3030, 0, 0, 0, 0};
    vecs[6]  = '{3'd2, 1'b0, 1'b0, 16'h1200, 16'h0034, 16'h1234, 0, 0, 0, 0};
    vecs[7]  = '{3'd4, 1'b0, 1'b0, 16'hBEEF, 16'hBEEF, 16'hBEEF, 0, 0, 0, 1};
    vecs[8]  = '{3'd0, 1'b0, 1'b1, 16'h00FF, 16'h0000, 16'h0100, 0, 0, 0, 0};
    vecs[9]  = '{3'd6, 1'b0, 1'b1, 16'h0002, 16'h0000, 16'h8001, 0, 0, 0, 0};
    vecs[10] = '{3'd0, 1'b1, 1'b0, 16'h0001, 16'h0001, 16'hFFFD, 0, 0, 0, 1};
    vecs[11] = '{3'd5, 1'b1, 1'b0, 16'h0000, 16'hFFFF, 16'h0000, 0, 1, 0, 0};

    host_if.start = 1'b0;
    drive_cmd(3'd0, 1'b0, 1'b0, '0, '0);

    // Reset values
    #12;
    check("rst busy_done", 32'({host_if.busy, host_if.done}), 32'd0);
    check("rst result", 32'(host_if.result), 32'd0);
    check("rst flags", 32'({host_if.cout, host_if.zero, host_if.neg_zero, host_if.equ}), 32'd0);
    check("rst alu", 32'({alu_a, alu_b, alu_f, alu_com, alu_ci_right, alu_ci_left}), 32'd0);
    $display("reset: busy=%b done=%b result=%h", host_if.busy, host_if.done, host_if.result);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) run_vec(vecs[i], $sformatf("v%0d", i));

    // SHR presents nibbles MSB first with cin entering on the left.
    @(negedge clk);
    drive_cmd(3'd6, 1'b0, 1'b1, 16'h8001, 16'h0000);
    host_if.start = 1'b1;
    @(posedge clk); #1;
    host_if.start = 1'b0;
    check("shr first alu_f", 32'(alu_f), 32'd6);
    check("shr first ci", 32'({alu_ci_left, alu_ci_right}), 32'b10);
    seq[0] = alu_a;
    for (int k = 1; k < 4; k++) begin
      @(posedge clk); #1;
      seq[k] = alu_a;
    end
    check("shr alu_a order", 32'({seq[0], seq[1], seq[2], seq[3]}), 32'h8001);
    @(posedge clk); #1;
    check("shr done", 32'(host_if.done), 32'd1);
    check("shr result_cin1", 32'(host_if.result), 32'hC000);
    $display("shr order: %h %h %h %h result=%h", seq[0], seq[1], seq[2], seq[3], host_if.result);

    // Back-to-back: start held high, second command accepted in done cycle.
    @(negedge clk);
    drive_cmd(3'd5, 1'b0, 1'b0, 16'h0000, 16'h00C3);
    host_if.start = 1'b1;
    @(posedge clk); #1;
    host_if.b = 16'h0000;
    wait_done(cyc);
    check("b2b first latency", 32'(cyc), 32'(NIBBLES));
    check("b2b first result", 32'(host_if.result), 32'h00C3);
    check("b2b first zero", 32'(host_if.zero), 32'd0);
    @(posedge clk); #1;
    host_if.start = 1'b0;
    check("b2b reaccept busy_done", 32'({host_if.busy, host_if.done}), 32'b10);
    wait_done(cyc);
    check("b2b second latency", 32'(cyc), 32'(NIBBLES));
    check("b2b second result", 32'(host_if.result), 32'h0000);
    check("b2b second zero", 32'(host_if.zero), 32'd1);
    $display("b2b: second result=%h zero=%b", host_if.result, host_if.zero);
    @(posedge clk); #1;

    // Start pulse in RUN is dropped, not queued.
    @(negedge clk);
    drive_cmd(3'd0, 1'b0, 1'b0, 16'h0001, 16'h0001);
    host_if.start = 1'b1;
    @(posedge clk); #1;
    host_if.start = 1'b0;
    @(posedge clk); #1;
    host_if.start = 1'b1;
    drive_cmd(3'd0, 1'b0, 1'b0, 16'h7777, 16'h7777);
    @(posedge clk); #1;
    host_if.start = 1'b0;
    wait_done(cyc);
    check("drop latency", 32'(cyc + 2), 32'(NIBBLES));
    check("drop result", 32'(host_if.result), 32'h0002);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("drop no_rerun", 32'({host_if.busy, host_if.done}), 32'd0);
    $display("drop: result=%h busy=%b", host_if.result, host_if.busy);

    // Reset in the middle of an ADD clears everything at once.
    @(negedge clk);
    drive_cmd(3'd0, 1'b0, 1'b0, 16'h5555, 16'h1111);
    host_if.start = 1'b1;
    @(posedge clk); #1;
    host_if.start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("midrst busy_done", 32'({host_if.busy, host_if.done}), 32'd0);
    check("midrst result", 32'(host_if.result), 32'd0);
    check("midrst alu", 32'({alu_a, alu_b, alu_f}), 32'd0);
    $display("midrst: busy=%b done=%b result=%h", host_if.busy, host_if.done, host_if.result);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("postrst idle", 32'({host_if.busy, host_if.done}), 32'd0);
    run_vec('{3'd0, 1'b0, 1'b0, 16'h1111, 16'h2222, 16'h3333, 0, 0, 0, 0}, "postrst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end
endmodule
